mac_dbg_ahb_master: RTL and testbench

- Downstream consumer of the MAC controller's debug AHB test registers.
- Converts each one-cycle debug request pulse (address, direction, write data) into one single-beat, word-sized AHB-Lite transfer.
- Returns a one-cycle completion pulse with read data or error status, which the controller latches into its debug read-back register.
- Sits between the controller and the cluster's AHB-Lite debug path; one transfer outstanding at a time.

---
 rtl/mac_dbg_ahb_master_pkg.sv | 27 ++
 rtl/mac_dbg_ahb_master.sv | 169 ++++++++++++++++
 tb/tb_mac_dbg_ahb_master.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mac_dbg_ahb_master_pkg.sv
// Shared types and AHB-Lite encodings for the MAC debug AHB master.
// Used by mac_dbg_ahb_master (optional timeout feature: MAC_DBG_AHB_TIMEOUT_EN).
package mac_dbg_ahb_master_pkg;

  typedef enum logic [1:0] {
    DBG_AHB_IDLE = 2'd0,
    DBG_AHB_ADDR = 2'd1,
    DBG_AHB_DATA = 2'd2
  } mac_dbg_ahb_state_e;

  localparam logic [1:0]  AHB_HTRANS_IDLE      = 2'b00;
  localparam logic [1:0]  AHB_HTRANS_NONSEQ    = 2'b10;
  localparam logic [2:0]  AHB_HSIZE_WORD       = 3'b010;
  localparam logic [2:0]  AHB_HBURST_SINGLE    = 3'b000;
  localparam logic [31:0] DBG_AHB_TIMEOUT_DATA = 32'hDEAD_BEEF;

  typedef struct packed {
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [2:0]  hburst;
    logic [3:0]  hprot;
    logic [31:0] hwdata;
  } ahb_dbg_master_t;

endpackage

// File: rtl/mac_dbg_ahb_master.sv
// Turns one-cycle debug request pulses into single-beat word AHB-Lite transfers.
// Define MAC_DBG_AHB_TIMEOUT_EN to abort phases stuck on hready_i=0.
module mac_dbg_ahb_master
  import mac_dbg_ahb_master_pkg::*;
#(
  parameter logic [3:0]  HPROT_VAL      = 4'b0011,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        clear_i,
  input  logic        dbg_hreq_i,
  input  logic [31:0] dbg_haddr_i,
  input  logic        dbg_hwen_i,
  input  logic [31:0] dbg_hwdata_i,
  output logic        dbg_hrvalid_o,
  output logic [31:0] dbg_hrdata_o,
  output logic        dbg_herr_o,
  output logic        busy_o,
  output logic        dropped_o,
  output logic [31:0] haddr_o,
  output logic [1:0]  htrans_o,
  output logic        hwrite_o,
  output logic [2:0]  hsize_o,
  output logic [2:0]  hburst_o,
  output logic [3:0]  hprot_o,
  output logic [31:0] hwdata_o,
  input  logic [31:0] hrdata_i,
  input  logic        hready_i,
  input  logic        hresp_i
);

  // Handshake: dbg_hreq_i is a pulse accepted only in IDLE; each accepted
  // request yields exactly one dbg_hrvalid_o pulse unless cleared/reset first.
  mac_dbg_ahb_state_e state_q;
  logic [1:0]         htrans_q;
  logic [31:0]        haddr_q;
  logic               hwrite_q;
  logic [31:0]        wdata_q;
  logic [31:0]        hwdata_q;
  logic               rvalid_q;
  logic [31:0]        rdata_q;
  logic               err_q;
  logic               dropped_q;
  logic               timeout_hit;
  ahb_dbg_master_t    ahb;

  logic unused_addr_bits;
  assign unused_addr_bits = ^dbg_haddr_i[1:0];

`ifdef MAC_DBG_AHB_TIMEOUT_EN
  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [CNT_W-1:0] wcnt_q;

  // Counts consecutive wait states of the current phase only.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wcnt_q <= '0;
    end else if (clear_i || state_q == DBG_AHB_IDLE || hready_i) begin
      wcnt_q <= '0;
    end else if (!timeout_hit) begin
      wcnt_q <= wcnt_q + CNT_W'(1);
    end
  end

  assign timeout_hit = (state_q != DBG_AHB_IDLE) && !hready_i &&
                       (wcnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  localparam bit unused_timeout = (TIMEOUT_CYCLES != 0);
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= DBG_AHB_IDLE;
      htrans_q  <= AHB_HTRANS_IDLE;
      haddr_q   <= '0;
      hwrite_q  <= 1'b0;
      wdata_q   <= '0;
      hwdata_q  <= '0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
      dropped_q <= 1'b0;
    end else if (clear_i) begin
      state_q   <= DBG_AHB_IDLE;
      htrans_q  <= AHB_HTRANS_IDLE;
      haddr_q   <= '0;
      hwrite_q  <= 1'b0;
      wdata_q   <= '0;
      hwdata_q  <= '0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
      dropped_q <= 1'b0;
    end else begin
      rvalid_q <= 1'b0;
      if (dbg_hreq_i && state_q != DBG_AHB_IDLE) begin
        dropped_q <= 1'b1;
      end
      if (timeout_hit) begin
        state_q  <= DBG_AHB_IDLE;
        htrans_q <= AHB_HTRANS_IDLE;
        hwdata_q <= '0;
        rvalid_q <= 1'b1;
        err_q    <= 1'b1;
        rdata_q  <= DBG_AHB_TIMEOUT_DATA;
      end else begin
        unique case (state_q)
          DBG_AHB_IDLE: begin
            if (dbg_hreq_i) begin
              haddr_q  <= {dbg_haddr_i[31:2], 2'b00};
              hwrite_q <= dbg_hwen_i;
              wdata_q  <= dbg_hwdata_i;
              htrans_q <= AHB_HTRANS_NONSEQ;
              state_q  <= DBG_AHB_ADDR;
            end
          end
          DBG_AHB_ADDR: begin
            if (hready_i) begin
              htrans_q <= AHB_HTRANS_IDLE;
              hwdata_q <= hwrite_q ? wdata_q : '0;
              state_q  <= DBG_AHB_DATA;
            end
          end
          DBG_AHB_DATA: begin
            if (hready_i) begin
              // A read that ends in ERROR returns zero rather than bus garbage.
              rdata_q  <= hwrite_q ? wdata_q : (hresp_i ? '0 : hrdata_i);
              err_q    <= hresp_i;
              rvalid_q <= 1'b1;
              hwdata_q <= '0;
              state_q  <= DBG_AHB_IDLE;
            end
          end
          default: begin
            htrans_q <= AHB_HTRANS_IDLE;
            state_q  <= DBG_AHB_IDLE;
          end
        endcase
      end
    end
  end

  always_comb begin
    ahb        = '0;
    ahb.haddr  = haddr_q;
    ahb.htrans = htrans_q;
    ahb.hwrite = hwrite_q;
    ahb.hsize  = AHB_HSIZE_WORD;
    ahb.hburst = AHB_HBURST_SINGLE;
    ahb.hprot  = HPROT_VAL;
    ahb.hwdata = hwdata_q;
  end

  assign haddr_o       = ahb.haddr;
  assign htrans_o      = ahb.htrans;
  assign hwrite_o      = ahb.hwrite;
  assign hsize_o       = ahb.hsize;
  assign hburst_o      = ahb.hburst;
  assign hprot_o       = ahb.hprot;
  assign hwdata_o      = ahb.hwdata;
  assign dbg_hrvalid_o = rvalid_q;
  assign dbg_hrdata_o  = rdata_q;
  assign dbg_herr_o    = err_q;
  assign busy_o        = (state_q != DBG_AHB_IDLE);
  assign dropped_o     = dropped_q;

endmodule

// File: tb/tb_mac_dbg_ahb_master.sv
// Self-checking bench for mac_dbg_ahb_master: directed transfers against a
// transaction-level model plus hand-computed literal expectations.
module tb_mac_dbg_ahb_master;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clear;
  logic        dbg_hreq;
  logic [31:0] dbg_haddr;
  logic        dbg_hwen;
  logic [31:0] dbg_hwdata;
  logic        dbg_hrvalid;
  logic [31:0] dbg_hrdata;
  logic        dbg_herr;
  logic        busy;
  logic        dropped;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [2:0]  hburst;
  logic [3:0]  hprot;
  logic [31:0] hwdata;
  logic [31:0] hrdata;
  logic        hready;
  logic        hresp;

  mac_dbg_ahb_master dut (
    .clk_i(clk), .rst_ni(rst_n), .clear_i(clear),
    .dbg_hreq_i(dbg_hreq), .dbg_haddr_i(dbg_haddr), .dbg_hwen_i(dbg_hwen),
    .dbg_hwdata_i(dbg_hwdata), .dbg_hrvalid_o(dbg_hrvalid), .dbg_hrdata_o(dbg_hrdata),
    .dbg_herr_o(dbg_herr), .busy_o(busy), .dropped_o(dropped),
    .haddr_o(haddr), .htrans_o(htrans), .hwrite_o(hwrite), .hsize_o(hsize),
    .hburst_o(hburst), .hprot_o(hprot), .hwdata_o(hwdata),
    .hrdata_i(hrdata), .hready_i(hready), .hresp_i(hresp)
  );

  // Clock / reset
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_total = 0;
  int n_pass  = 0;
  int n_nonseq = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Transaction-level model: phase 0 = no transfer, 1 = address, 2 = data
  int          m_phase    = 0;
  bit          m_pristine = 1'b1;
  logic [31:0] m_addr     = '0;
  bit          m_wr       = 1'b0;
  logic [31:0] m_wd       = '0;
  bit          m_rvalid   = 1'b0;
  logic [31:0] m_rdata    = '0;
  bit          m_err      = 1'b0;
  bit          m_dropped  = 1'b0;
  logic [32:0] exp_q[$];

  always @(posedge clk) begin
    if (!rst_n || clear) begin
      m_phase = 0; m_pristine = 1'b1; m_addr = '0; m_wr = 1'b0; m_wd = '0;
      m_rvalid = 1'b0; m_rdata = '0; m_err = 1'b0; m_dropped = 1'b0;
    end else begin
      m_rvalid = 1'b0;
      if (m_phase == 0) begin
        if (dbg_hreq) begin
          m_phase = 1; m_pristine = 1'b0;
          m_addr = {dbg_haddr[31:2], 2'b00}; m_wr = dbg_hwen; m_wd = dbg_hwdata;
        end
      end else begin
        if (dbg_hreq) m_dropped = 1'b1;
        if (hready) begin
          if (m_phase == 1) begin
            m_phase = 2;
          end else begin
            m_phase  = 0;
            m_rvalid = 1'b1;
            m_err    = hresp;
            m_rdata  = m_wr ? m_wd : (hresp ? 32'h0 : hrdata);
            exp_q.push_back({m_err, m_rdata});
          end
        end
      end
    end
  end

  // Scoreboard: every cycle, on the falling edge
  always @(negedge clk) begin
    logic [32:0] e;
    chk("htrans", htrans, (m_phase == 1) ? 2'b10 : 2'b00);
    chk("busy", busy, m_phase != 0);
    chk("dropped", dropped, m_dropped);
    chk("hrvalid", dbg_hrvalid, m_rvalid);
    chk("hrdata", dbg_hrdata, m_rdata);
    chk("herr", dbg_herr, m_err);
    chk("hsize", hsize, 3'b010);
    chk("hburst", hburst, 3'b000);
    chk("hprot", hprot, 4'b0011);
    if (m_phase == 1 || m_pristine) begin
      chk("haddr", haddr, m_addr);
      chk("hwrite", hwrite, m_wr);
    end
    if (m_phase == 2 || m_pristine) chk("hwdata", hwdata, (m_phase == 2 && m_wr) ? m_wd : 32'h0);
    if (htrans == 2'b10 && hready) n_nonseq++;
    if (dbg_hrvalid) begin
      chk("completion_pending", exp_q.size() > 0, 1'b1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("completion", {dbg_herr, dbg_hrdata}, e);
      end
    end
  end

  // Driver tasks: inputs change 1ns after the rising edge
  task automatic drv(input bit rq, input logic [31:0] a, input bit w, input logic [31:0] wd,
                     input bit hr, input bit rsp, input logic [31:0] rd, input bit clr);
    dbg_hreq = rq; dbg_haddr = a; dbg_hwen = w; dbg_hwdata = wd;
    hready = hr; hresp = rsp; hrdata = rd; clear = clr;
    @(posedge clk); #1;
  endtask

  task automatic idle();
    drv(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
  endtask

  int t0;
  int nonseq_before;

  initial begin
    rst_n = 1'b0; clear = 1'b0; dbg_hreq = 1'b0; dbg_haddr = '0; dbg_hwen = 1'b0;
    dbg_hwdata = '0; hrdata = '0; hready = 1'b1; hresp = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    chk("rst_htrans", htrans, 2'b00);
    chk("rst_busy", busy, 1'b0);
    chk("rst_dropped", dropped, 1'b0);
    chk("rst_hrvalid", dbg_hrvalid, 1'b0);
    chk("rst_hrdata", dbg_hrdata, 32'h0);
    chk("rst_haddr", haddr, 32'h0);
    chk("rst_hwdata", hwdata, 32'h0);
    idle();

    // Read, zero wait states
    t0 = cyc;
    drv(1'b1, 32'h1000_0004, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
    chk("s1_nonseq_c1", htrans, 2'b10);
    chk("s1_haddr", haddr, 32'h1000_0004);
    chk("s1_hwrite", hwrite, 1'b0);
    idle();
    chk("s1_idle_c2", htrans, 2'b00);
    drv(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0, 32'hCAFE_0001, 1'b0);
    chk("s1_hrvalid_c3", dbg_hrvalid, 1'b1);
    chk("s1_latency", cyc - t0, 3);
    chk("s1_hrdata", dbg_hrdata, 32'hCAFE_0001);
    chk("s1_herr", dbg_herr, 1'b0);

    // Write issued back-to-back in the completion cycle, 3 data wait states
    t0 = cyc;
    drv(1'b1, 32'h2000_0008, 1'b1, 32'h1234_5678, 1'b1, 1'b0, 32'h0, 1'b0);
    chk("s2_haddr", haddr, 32'h2000_0008);
    chk("s2_hwrite", hwrite, 1'b1);
    idle();
    for (int i = 0; i < 3; i++) begin
      chk("s2_hwdata_wait", hwdata, 32'h1234_5678);
      drv(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    end
    chk("s2_hwdata_last", hwdata, 32'h1234_5678);
    drv(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0, 32'hFFFF_0000, 1'b0);
    chk("s2_hrvalid_c6", dbg_hrvalid, 1'b1);
    chk("s2_latency", cyc - t0, 6);
    chk("s2_echo", dbg_hrdata, 32'h1234_5678);

    // Unaligned read address and fixed control fields
    t0 = cyc;
    drv(1'b1, 32'h3000_0003, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
    chk("s3_haddr_aligned", haddr, 32'h3000_0000);
    chk("s3_hsize", hsize, 3'b010);
    chk("s3_hburst", hburst, 3'b000);
    idle();
    drv(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h5555_AAAA, 1'b0);
    chk("s3_hrdata", dbg_hrdata, 32'h5555_AAAA);
    idle();
    chk("s3_hrvalid_drop", dbg_hrvalid, 1'b0);
    chk("s3_hrdata_hold", dbg_hrdata, 32'h5555_AAAA);

    // Two-cycle ERROR response on a read, then a clean read
    t0 = cyc;
    drv(1'b1, 32'h4000_0010, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
    idle();
    drv(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 32'hFFFF_FFFF, 1'b0);
    chk("s4_err_wait_busy", busy, 1'b1);
    drv(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1, 32'hFFFF_FFFF, 1'b0);
    chk("s4_hrvalid", dbg_hrvalid, 1'b1);
    chk("s4_latency", cyc - t0, 4);
    chk("s4_herr", dbg_herr, 1'b1);
    chk("s4_hrdata_zero", dbg_hrdata, 32'h0);
    drv(1'b1, 32'h4000_0014, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
    idle();
    drv(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0000_0077, 1'b0);
    chk("s4_next_herr", dbg_herr, 1'b0);
    chk("s4_next_hrdata", dbg_hrdata, 32'h0000_0077);
    idle();

    // Request while busy is dropped; only one transfer reaches the bus
    drv(1'b1, 32'h5000_0000, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
    nonseq_before = n_nonseq;
    drv(1'b1, 32'h6000_0000, 1'b1, 32'h0000_DEAD, 1'b1, 1'b0, 32'h0, 1'b0);
    chk("s5_dropped", dropped, 1'b1);
    drv(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h1357_9BDF, 1'b0);
    chk("s5_hrdata", dbg_hrdata, 32'h1357_9BDF);
    idle();
    idle();
    chk("s5_one_transfer", n_nonseq - nonseq_before, 1);
    chk("s5_busy_after", busy, 1'b0);

    // clear_i during the data phase
    drv(1'b1, 32'h7000_0000, 1'b1, 32'hA5A5_A5A5, 1'b1, 1'b0, 32'h0, 1'b0);
    idle();
    chk("s6_hwdata", hwdata, 32'hA5A5_A5A5);
    drv(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1);
    chk("s6_busy_clr", busy, 1'b0);
    chk("s6_htrans_clr", htrans, 2'b00);
    chk("s6_dropped_clr", dropped, 1'b0);
    chk("s6_hrvalid_clr", dbg_hrvalid, 1'b0);
    idle();
    chk("s6_no_late_hrvalid", dbg_hrvalid, 1'b0);

    // clear_i wins over a simultaneous request
    drv(1'b1, 32'h8000_0000, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1);
    chk("s7_clear_priority", busy, 1'b0);
    idle();
    idle();

    chk("nonseq_total", n_nonseq, 7);
    chk("exp_q_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
